// File: rtl/reset_sequencer_if.sv
// Lock input and staged reset outputs of the post-PLL reset sequencer.
// The slave modport is the sequencer and the master modport is its environment.
interface reset_sequencer_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
);

   logic              i_locked;
   logic [NUM_CH-1:0] o_rst;
   logic              o_ready;
   logic [CNT_W-1:0]  o_loss_cnt;
   logic [1:0]        o_state;

   modport master (
      output i_locked,
      input  o_rst,
      input  o_ready,
      input  o_loss_cnt,
      input  o_state
   );

   modport slave (
      input  i_locked,
      output o_rst,
      output o_ready,
      output o_loss_cnt,
      output o_state
   );

endinterface

// File: rtl/reset_sequencer.sv
// Post-PLL reset sequencer: synchronises and filters the lock flag, holds reset,
// then releases NUM_CH resets in staggered order. Every loss of lock is counted.
module reset_sequencer #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8,
   parameter int HOLD_CYCLES = 1024,
   parameter int STAGE_GAP   = 16,
   parameter int CNT_W       = 8
) (
   input logic               i_clk,
   input logic               i_rst_n,
   reset_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_WAIT    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   localparam int FILT_W = $clog2(FILTER_LEN + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int GAP_W  = $clog2(STAGE_GAP + 1);
   localparam int CH_W   = $clog2(NUM_CH + 1);

   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
   localparam logic [CH_W-1:0]   CH_END    = CH_W'(NUM_CH);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [FILT_W-1:0]      filt_q, filt_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic [CH_W-1:0]        ch_q, ch_d;
   logic [NUM_CH-1:0]      rst_q, rst_d;
   logic                   ready_q, ready_d;
   logic [CNT_W-1:0]       loss_q, loss_d;
   logic                   lk_s;

   assign lk_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q  <= '0;
         state_q <= ST_WAIT;
         filt_q  <= '0;
         hold_q  <= '0;
         gap_q   <= '0;
         ch_q    <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
         loss_q  <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         filt_q  <= filt_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         ch_q    <= ch_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         loss_q  <= loss_d;
      end
   end

   // ch_q is the next channel to release; gap_q spaces the releases STAGE_GAP edges apart.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], bus.i_locked};
      state_d = state_q;
      filt_d  = filt_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      ch_d    = ch_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      loss_d  = loss_q;

      case (state_q)
         ST_WAIT: begin
            rst_d   = '1;
            ready_d = 1'b0;
            if (!lk_s) begin
               filt_d = '0;
            end else if (filt_q == FILT_LAST) begin
               filt_d  = '0;
               hold_d  = '0;
               state_d = ST_HOLD;
            end else begin
               filt_d = filt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               hold_d   = '0;
               gap_d    = '0;
               ch_d     = CH_W'(1);
               rst_d[0] = 1'b0;
               state_d  = ST_RELEASE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (ch_q == CH_END) begin
               ready_d = 1'b1;
               state_d = ST_RUN;
            end else if (gap_q == GAP_LAST) begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (CH_W'(k) == ch_q) begin
                     rst_d[k] = 1'b0;
                  end
               end
               ch_d  = ch_q + 1'b1;
               gap_d = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_RUN: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase

      // Losing lock after it was accepted overrides everything and restarts the sequence.
      if (state_q != ST_WAIT && !lk_s) begin
         state_d = ST_WAIT;
         rst_d   = '1;
         ready_d = 1'b0;
         filt_d  = '0;
         hold_d  = '0;
         gap_d   = '0;
         ch_d    = '0;
         if (loss_q != '1) begin
            loss_d = loss_q + 1'b1;
         end
      end
   end

   assign bus.o_rst      = rst_q;
   assign bus.o_ready    = ready_q;
   assign bus.o_loss_cnt = loss_q;
   assign bus.o_state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expectations are queued per clock edge
// and compared when the run reaches that edge.
module tb_reset_sequencer;

   localparam int NUM_CH      = 3;
   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 4;
   localparam int HOLD_CYCLES = 8;
   localparam int STAGE_GAP   = 2;
   localparam int CNT_W       = 2;

   localparam logic [1:0] S_WAIT = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_REL  = 2'd2;
   localparam logic [1:0] S_RUN  = 2'd3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   reset_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   reset_sequencer #(
      .NUM_CH      (NUM_CH),
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .HOLD_CYCLES (HOLD_CYCLES),
      .STAGE_GAP   (STAGE_GAP),
      .CNT_W       (CNT_W)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_no;
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   edge_no = 0;
   int   total   = 0;
   int   bad     = 0;

   task automatic push_exp(input int e, input string tag, input logic [2:0] r,
                           input logic rd, input logic [1:0] st, input logic [1:0] lc);
      exp_t item;
      item.edge_no = e;
      item.tag     = tag;
      item.exp     = {r, rd, st, lc};
      sb_q.push_back(item);
   endtask

   task automatic check_output();
      exp_t       item;
      logic [7:0] obs;
      while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_no) begin
         item = sb_q.pop_front();
         obs  = {bus.o_rst, bus.o_ready, bus.o_state, bus.o_loss_cnt};
         total++;
         assert (obs === item.exp) else begin
            bad++;
            $error("[TB] FAIL %s @E%0d: got rst=%b ready=%b state=%0d loss=%0d, want rst=%b ready=%b state=%0d loss=%0d",
                   item.tag, edge_no, obs[7:5], obs[4], obs[3:2], obs[1:0],
                   item.exp[7:5], item.exp[4], item.exp[3:2], item.exp[1:0]);
         end
      end
   endtask

   task automatic run_to(input int e);
      while (edge_no < e) begin
         @(posedge clk);
         #1;
         edge_no++;
         check_output();
      end
   endtask

   task automatic apply_stimulus(input logic locked);
      @(negedge clk);
      rst_n        = 1'b0;
      bus.i_locked = locked;
      #1;
      push_exp(edge_no, "in reset", 3'b111, 1'b0, S_WAIT, 2'd0);
      check_output();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      edge_no = -1;
   endtask

   // Timeline of a full lock sequence whose lock input is first sampled high at edge e0.
   task automatic push_lock_seq(input int e0, input logic [1:0] lc, input string pfx);
      push_exp(e0 + 4,  {pfx, " filter"},   3'b111, 1'b0, S_WAIT, lc);
      push_exp(e0 + 5,  {pfx, " hold in"},  3'b111, 1'b0, S_HOLD, lc);
      push_exp(e0 + 13, {pfx, " hold end"}, 3'b111, 1'b0, S_HOLD, lc);
      push_exp(e0 + 14, {pfx, " rst0"},     3'b110, 1'b0, S_REL,  lc);
      push_exp(e0 + 15, {pfx, " gap0"},     3'b110, 1'b0, S_REL,  lc);
      push_exp(e0 + 16, {pfx, " rst1"},     3'b100, 1'b0, S_REL,  lc);
      push_exp(e0 + 17, {pfx, " gap1"},     3'b100, 1'b0, S_REL,  lc);
      push_exp(e0 + 18, {pfx, " rst2"},     3'b000, 1'b0, S_REL,  lc);
      push_exp(e0 + 19, {pfx, " ready"},    3'b000, 1'b1, S_RUN,  lc);
   endtask

   initial begin
      logic [1:0] lc_before;
      logic [1:0] lc_after;

      // Lock bounce shorter than the filter never leaves WAIT
      apply_stimulus(1'b0);
      push_exp(7,  "bounce e7",  3'b111, 1'b0, S_WAIT, 2'd0);
      push_exp(8,  "bounce e8",  3'b111, 1'b0, S_WAIT, 2'd0);
      push_exp(12, "bounce e12", 3'b111, 1'b0, S_WAIT, 2'd0);
      push_exp(20, "bounce e20", 3'b111, 1'b0, S_WAIT, 2'd0);
      run_to(2);
      bus.i_locked = 1'b1;
      run_to(5);
      bus.i_locked = 1'b0;
      run_to(20);

      // Clean start with lock already present
      apply_stimulus(1'b1);
      push_lock_seq(0, 2'd0, "s1");
      push_exp(20, "s1 run", 3'b000, 1'b1, S_RUN, 2'd0);
      // One-cycle lock drop while running, then a full repeat
      push_exp(22, "s3 pre",  3'b000, 1'b1, S_RUN,  2'd0);
      push_exp(23, "s3 loss", 3'b111, 1'b0, S_WAIT, 2'd1);
      push_lock_seq(22, 2'd1, "s3");
      run_to(20);
      bus.i_locked = 1'b0;
      run_to(21);
      bus.i_locked = 1'b1;
      run_to(41);

      // Lock drops during HOLD and during RELEASE
      apply_stimulus(1'b1);
      push_exp(7,  "s4 hold",      3'b111, 1'b0, S_HOLD, 2'd0);
      push_exp(9,  "s4 hold pre",  3'b111, 1'b0, S_HOLD, 2'd0);
      push_exp(10, "s4 hold loss", 3'b111, 1'b0, S_WAIT, 2'd1);
      push_exp(23, "s4 rel0",      3'b110, 1'b0, S_REL,  2'd1);
      push_exp(25, "s4 rel1",      3'b100, 1'b0, S_REL,  2'd1);
      push_exp(26, "s4 rel loss",  3'b111, 1'b0, S_WAIT, 2'd2);
      push_lock_seq(25, 2'd2, "s4");
      run_to(7);
      bus.i_locked = 1'b0;
      run_to(8);
      bus.i_locked = 1'b1;
      run_to(23);
      bus.i_locked = 1'b0;
      run_to(24);
      bus.i_locked = 1'b1;
      run_to(44);

      // Five losses in HOLD saturate the 2-bit counter
      apply_stimulus(1'b1);
      for (int k = 0; k < 5; k++) begin
         lc_before = (k > 3) ? 2'd3 : 2'(k);
         lc_after  = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
         push_exp(7 + 7 * k, "s5 hold", 3'b111, 1'b0, S_HOLD, lc_before);
         push_exp(8 + 7 * k, "s5 loss", 3'b111, 1'b0, S_WAIT, lc_after);
         run_to(5 + 7 * k);
         bus.i_locked = 1'b0;
         run_to(6 + 7 * k);
         bus.i_locked = 1'b1;
      end

      // Asynchronous reset in the middle of RELEASE, then a clean restart
      push_exp(49, "s6 rel0", 3'b110, 1'b0, S_REL, 2'd3);
      push_exp(51, "s6 rel1", 3'b100, 1'b0, S_REL, 2'd3);
      run_to(51);
      rst_n = 1'b0;
      #2;
      push_exp(edge_no, "s6 async", 3'b111, 1'b0, S_WAIT, 2'd0);
      check_output();
      apply_stimulus(1'b1);
      push_lock_seq(0, 2'd0, "s6");
      run_to(20);

      total++;
      assert (sb_q.size() == 0) else begin
         bad++;
         $error("[TB] FAIL leftover: got %0d pending expectations, want 0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
